// File: rtl/store_db_pkg.sv
// Shared types and constants for the deblocked-LCU store drain path.
package store_db_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int WORD_W      = 32 * PIXEL_WIDTH;
    localparam int LUMA_WORDS  = 128;
    localparam int TOTAL_WORDS = 192;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // One buffered word: pixel data plus what is needed to rebuild its coordinates.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sel;
        logic [5:0]        row;
        logic              half;
    } fifo_word_t;

    // Luma words fill 0..127 (two words per 64-sample row); chroma rows follow
    // as 64 interleaved u/v samples, again two words per row.
    function automatic fifo_word_t word_tag(input logic [7:0] addr,
                                            input logic [WORD_W-1:0] data);
        fifo_word_t w;
        w.data = data;
        w.sel  = (addr >= 8'(LUMA_WORDS));
        w.row  = w.sel ? {1'b0, addr[5:1]} : addr[6:1];
        w.half = addr[0];
        return w;
    endfunction

endpackage

// File: rtl/store_db_if.sv
// External-memory write port: one 32-sample word per valid/ready transfer.
interface store_db_if
    import store_db_pkg::*;
#(
    parameter int PIC_X_WIDTH = 8,
    parameter int PIC_Y_WIDTH = 8
) ();

    logic                   valid;
    logic                   ready;
    logic                   sel;
    logic [PIC_X_WIDTH+5:0] x;
    logic [PIC_Y_WIDTH+5:0] y;
    logic [WORD_W-1:0]      data;

    modport master (output valid, sel, x, y, data, input ready);
    modport slave  (input valid, sel, x, y, data, output ready);

endinterface

// File: rtl/store_db_fifo.sv
// Two-entry skid FIFO between the buffer read port and the write interface.
// The caller never pushes when full nor pops when empty.
module store_db_fifo
    import store_db_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  fifo_word_t push_word,
    input  logic       pop,
    output fifo_word_t head,
    output logic [1:0] count
);

    fifo_word_t mem [FIFO_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;

    // Storage and pointers; storage is cleared so the outputs read zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/store_db.sv
// Drains one finished LCU from the store buffer to external memory.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a start from the system controller
//   S_WAIT  | LCU accepted, waiting for the buffer to hold a finished LCU
//   S_RUN   | issuing buffer reads 0..191 as FIFO space allows
//   S_DRAIN | all reads issued, emptying FIFO; done pulses on last accept
module store_db
    import store_db_pkg::*;
#(
    parameter int PIC_X_WIDTH = 8,
    parameter int PIC_Y_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sysif_start_i,
    input  logic [PIC_X_WIDTH-1:0] sysif_x_i,
    input  logic [PIC_Y_WIDTH-1:0] sysif_y_i,
    output logic                   sysif_done_o,
    input  logic                   store_ready_i,
    output logic                   store_en_o,
    output logic [7:0]             store_addr_o,
    input  logic [WORD_W-1:0]      store_data_i,
    output logic                   store_done_o,
    store_db_if.master             extif
);

    state_t                 state, state_nxt;
    logic                   done_nxt, done_q;
    logic [PIC_X_WIDTH-1:0] lcu_x;
    logic [PIC_Y_WIDTH-1:0] lcu_y;
    logic [7:0]             rd_a;
    logic [7:0]             rd_addr_q;
    logic                   inflight_q;
    logic                   pop;
    logic                   room;
    logic [2:0]             occ_after;
    logic [1:0]             fifo_count;
    fifo_word_t             head;
    fifo_word_t             push_word;

    assign pop        = extif.valid & extif.ready;
    // Occupancy once this cycle's pop leaves and the in-flight read lands.
    assign occ_after  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign room       = (occ_after < 3'(FIFO_DEPTH));
    assign store_en_o = (state == S_RUN) && room;
    assign store_addr_o = rd_a;
    assign push_word  = word_tag(rd_addr_q, store_data_i);

    store_db_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_word (push_word),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Write-side view of the FIFO head; chroma rows are half as tall as luma.
    assign extif.valid = (fifo_count != 2'd0);
    assign extif.sel   = head.sel;
    assign extif.data  = head.data;
    assign extif.x     = {lcu_x, head.half, 5'b0};
    assign extif.y     = head.sel ? {1'b0, lcu_y, head.row[4:0]} : {lcu_y, head.row};

    // State register and registered done strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state decode; done is raised on the DRAIN -> IDLE transition.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE:  if (sysif_start_i) state_nxt = S_WAIT;
            S_WAIT:  if (store_ready_i) state_nxt = S_RUN;
            S_RUN:   if (store_en_o && (rd_a == 8'(TOTAL_WORDS - 1))) state_nxt = S_DRAIN;
            S_DRAIN: if (!inflight_q && (fifo_count == 2'd1) && pop) begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // LCU position capture, read address counter and in-flight read tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lcu_x      <= '0;
            lcu_y      <= '0;
            rd_a       <= 8'd0;
            rd_addr_q  <= 8'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= store_en_o;
            if (store_en_o) begin
                rd_addr_q <= rd_a;
                rd_a      <= rd_a + 8'd1;
            end
            if ((state == S_IDLE) && sysif_start_i) begin
                lcu_x <= sysif_x_i;
                lcu_y <= sysif_y_i;
                rd_a  <= 8'd0;
            end
        end
    end

    assign store_done_o = done_q;
    assign sysif_done_o = done_q;

endmodule

// File: tb/tb_store_db.sv
// Bench for store_db: buffer model, spec-derived scoreboard, vector table.
module tb_store_db;
    import store_db_pkg::*;

    typedef struct {
        int x;
        int y;
        bit rand_ready;
        int delay;
        bit mid_start;
        int exp_off;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [13:0] x;
        logic [13:0] y;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sysif_start_i = 1'b0;
    logic [7:0]   sysif_x_i = '0;
    logic [7:0]   sysif_y_i = '0;
    logic         sysif_done_o;
    logic         store_ready_i = 1'b0;
    logic         store_en_o;
    logic [7:0]   store_addr_o;
    logic [255:0] store_data_i = '0;
    logic         store_done_o;

    store_db_if #(.PIC_X_WIDTH(8), .PIC_Y_WIDTH(8)) ext_if ();

    store_db #(.PIC_X_WIDTH(8), .PIC_Y_WIDTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sysif_start_i (sysif_start_i),
        .sysif_x_i     (sysif_x_i),
        .sysif_y_i     (sysif_y_i),
        .sysif_done_o  (sysif_done_o),
        .store_ready_i (store_ready_i),
        .store_en_o    (store_en_o),
        .store_addr_o  (store_addr_o),
        .store_data_i  (store_data_i),
        .store_done_o  (store_done_o),
        .extif         (ext_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] mem [TOTAL_WORDS];
    exp_t exp_q[$];
    bit   rand_ready = 0;
    int   exp_rd = 0, issued = 0, accepted = 0;
    int   first_en = -1, first_val = -1;
    int   done_cnt = 0, done_cyc = -1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer read port model and write-side ready generation.
    initial begin
        logic       en_d;
        logic [7:0] a_d;
        ext_if.ready = 1'b1;
        forever begin
            @(negedge clk);
            en_d = store_en_o;
            a_d  = store_addr_o;
            @(posedge clk);
            #1;
            if (en_d && a_d < 8'(TOTAL_WORDS)) store_data_i = mem[a_d];
            else for (int k = 0; k < 8; k++) store_data_i[k*32 +: 32] = $urandom;
            ext_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: read order, occupancy bound, scoreboard, hold stability, done strobes.
    initial begin
        bit           hold_prev = 0;
        logic         p_sel;
        logic [13:0]  p_x, p_y;
        logic [255:0] p_data;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold_prev = 0;
            end else begin
                if (store_en_o) begin
                    checks++;
                    if (store_addr_o != 8'(exp_rd)) begin
                        errors++;
                        $display("FAIL rd_addr act=%0d req=%0d", store_addr_o, exp_rd);
                    end
                    if (first_en < 0) first_en = cyc;
                    exp_rd++;
                    issued++;
                end
                if (ext_if.valid && first_val < 0) first_val = cyc;
                if (hold_prev) begin
                    checks++;
                    if (!ext_if.valid || ext_if.sel !== p_sel || ext_if.x !== p_x ||
                        ext_if.y !== p_y || ext_if.data !== p_data) begin
                        errors++;
                        $display("FAIL hold act=%0b/%0d/%0d req=1/%0d/%0d", ext_if.valid,
                                 ext_if.x, ext_if.y, p_x, p_y);
                    end
                end
                hold_prev = ext_if.valid && !ext_if.ready;
                p_sel = ext_if.sel; p_x = ext_if.x; p_y = ext_if.y; p_data = ext_if.data;
                if (ext_if.valid && ext_if.ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word act=%0d/%0d req=none", ext_if.x, ext_if.y);
                    end else begin
                        e = exp_q.pop_front();
                        if (ext_if.sel !== e.sel || ext_if.x !== e.x || ext_if.y !== e.y ||
                            ext_if.data !== e.data) begin
                            errors++;
                            $display("FAIL word%0d act=%0b/%0d/%0d/%0h req=%0b/%0d/%0d/%0h",
                                     accepted, ext_if.sel, ext_if.x, ext_if.y, ext_if.data,
                                     e.sel, e.x, e.y, e.data);
                        end
                    end
                    accepted++;
                end
                if (store_en_o) begin
                    checks++;
                    if (issued - accepted > FIFO_DEPTH) begin
                        errors++;
                        $display("FAIL occupancy act=%0d req<=%0d", issued - accepted, FIFO_DEPTH);
                    end
                end
                if (sysif_done_o || store_done_o) begin
                    checks++;
                    if (sysif_done_o !== store_done_o) begin
                        errors++;
                        $display("FAIL done_pair act=%0b/%0b req=equal", sysif_done_o, store_done_o);
                    end
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic begin_lcu(input vec_t v, output int t0);
        exp_t e;
        for (int i = 0; i < TOTAL_WORDS; i++)
            for (int k = 0; k < 8; k++) mem[i][k*32 +: 32] = $urandom;
        exp_q.delete();
        for (int a = 0; a < TOTAL_WORDS; a++) begin
            int row, half;
            half  = a % 2;
            e.sel = (a >= 128);
            row   = e.sel ? (a - 128) / 2 : a / 2;
            e.x   = 14'(v.x * 64 + half * 32);
            e.y   = e.sel ? 14'(v.y * 32 + row) : 14'(v.y * 64 + row);
            e.data = mem[a];
            exp_q.push_back(e);
        end
        exp_rd = 0; issued = 0; accepted = 0; first_en = -1; first_val = -1;
        rand_ready    = v.rand_ready;
        store_ready_i = (v.delay == 0);
        sysif_x_i     = 8'(v.x);
        sysif_y_i     = 8'(v.y);
        sysif_start_i = 1'b1;
        t0 = cyc;
        tick();
        sysif_start_i = 1'b0;
        sysif_x_i     = ~8'(v.x);
        sysif_y_i     = ~8'(v.y);
        if (v.delay > 0) begin
            repeat (v.delay) tick();
            store_ready_i = 1'b1;
            repeat (10) tick();
            store_ready_i = 1'b0;
        end
        if (v.mid_start) begin
            repeat (30) tick();
            sysif_x_i     = 8'hAA;
            sysif_y_i     = 8'h55;
            sysif_start_i = 1'b1;
            tick();
            sysif_start_i = 1'b0;
        end
    endtask

    task automatic finish_lcu(input vec_t v, input int t0, input int done0);
        int n = 0;
        while (done_cnt == done0 && n < 3000) begin
            tick();
            n++;
        end
        chk("done_seen", 256'(done_cnt != done0), 256'(1));
        if (v.exp_off != 0) chk("done_cycle", 256'(done_cyc), 256'(t0 + v.exp_off + v.delay));
        repeat (5) tick();
        chk("done_once", 256'(done_cnt - done0), 256'(1));
        chk("queue_empty", 256'(exp_q.size()), 256'(0));
        chk("reads", 256'(issued), 256'(TOTAL_WORDS));
        chk("accepts", 256'(accepted), 256'(TOTAL_WORDS));
        chk("first_en", 256'(first_en), 256'(t0 + 2 + v.delay));
        chk("first_valid", 256'(first_val), 256'(t0 + 4 + v.delay));
        chk("idle_en", 256'(store_en_o), 256'(0));
        store_ready_i = 1'b0;
        rand_ready    = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_en"},    256'(store_en_o),   256'(0));
        chk({tag, "_addr"},  256'(store_addr_o), 256'(0));
        chk({tag, "_sdone"}, 256'(store_done_o), 256'(0));
        chk({tag, "_ydone"}, 256'(sysif_done_o), 256'(0));
        chk({tag, "_valid"}, 256'(ext_if.valid), 256'(0));
        chk({tag, "_sel"},   256'(ext_if.sel),   256'(0));
        chk({tag, "_x"},     256'(ext_if.x),     256'(0));
        chk({tag, "_y"},     256'(ext_if.y),     256'(0));
        chk({tag, "_data"},  ext_if.data,        256'(0));
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   t0, done0, n;

        vecs[0] = '{x: 3,   y: 2,   rand_ready: 0, delay: 0,  mid_start: 0, exp_off: 196};
        vecs[1] = '{x: 3,   y: 2,   rand_ready: 1, delay: 0,  mid_start: 0, exp_off: 0};
        vecs[2] = '{x: 255, y: 255, rand_ready: 0, delay: 20, mid_start: 0, exp_off: 196};
        vecs[3] = '{x: 7,   y: 1,   rand_ready: 0, delay: 0,  mid_start: 1, exp_off: 196};
        vecs[4] = '{x: 0,   y: 0,   rand_ready: 1, delay: 5,  mid_start: 1, exp_off: 0};

        repeat (3) tick();
        chk_outputs_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) tick();
        chk("idle_no_read", 256'(store_en_o), 256'(0));
        chk("idle_no_valid", 256'(ext_if.valid), 256'(0));
        chk("idle_no_done", 256'(done_cnt), 256'(0));

        for (int i = 0; i < 5; i++) begin
            done0 = done_cnt;
            begin_lcu(vecs[i], t0);
            finish_lcu(vecs[i], t0, done0);
        end

        // Abort mid-LCU with reset, then store a full LCU again.
        v = '{x: 9, y: 4, rand_ready: 0, delay: 0, mid_start: 0, exp_off: 196};
        done0 = done_cnt;
        begin_lcu(v, t0);
        n = 0;
        while (accepted < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("abort_reached", 256'(accepted >= 100), 256'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk_outputs_zero("abort");
        repeat (4) tick();
        chk("abort_no_done", 256'(done_cnt - done0), 256'(0));
        #2;
        rstn = 1'b1;
        repeat (3) tick();
        chk("abort_idle", 256'(store_en_o), 256'(0));
        done0 = done_cnt;
        begin_lcu(v, t0);
        finish_lcu(v, t0, done0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
